write_control_logic: RTL

WRITE_CONTROL_LOGIC -- requirements
Module: write_control_logic

---
 rtl/write_control_logic.sv | 87 ++++++++
 1 files changed

// File: rtl/write_control_logic.sv
// Write-side control for an asynchronous FIFO: binary/Gray write pointer,
// memory write strobe/address, and registered full / almost_full flags
// computed against the read pointer already synchronized into write_clk.
// Optional sticky overflow output: define WRITE_OVERFLOW_FLAG_EN.
module write_control_logic #(
  parameter int ADDR_WIDTH  = 3,
  parameter int AFULL_LEVEL = 6
) (
  input  logic                  write_clk,
  input  logic                  write_rst,
  input  logic                  write_enable,
  input  logic [ADDR_WIDTH:0]   r_synchronization,
  output logic                  full,
  output logic                  almost_full,
  output logic [ADDR_WIDTH-1:0] write_addr_out,
  output logic                  write_enable_out,
  output logic [ADDR_WIDTH:0]   write_addr_gray
`ifdef WRITE_OVERFLOW_FLAG_EN
  ,
  output logic                  overflow
`endif
);

  localparam logic [ADDR_WIDTH:0] AFULL_L = (ADDR_WIDTH+1)'(AFULL_LEVEL);

  logic [ADDR_WIDTH:0]   ptr_q, ptr_d;
  logic [ADDR_WIDTH:0]   gray_q, gray_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  wen_q, full_q, full_d, afull_q, afull_d;
  logic                  accept;
  logic [ADDR_WIDTH:0]   rbin, fill, full_cmp;

  // Next pointer, Gray-decoded read pointer and flag evaluation on the next pointer
  always_comb begin
    accept = write_enable & ~full_q;
    ptr_d  = ptr_q + {{ADDR_WIDTH{1'b0}}, accept};
    gray_d = ptr_d ^ (ptr_d >> 1);
    addr_d = accept ? ptr_q[ADDR_WIDTH-1:0] : addr_q;
    rbin   = '0;
    rbin[ADDR_WIDTH] = r_synchronization[ADDR_WIDTH];
    for (int i = ADDR_WIDTH-1; i >= 0; i--)
      rbin[i] = rbin[i+1] ^ r_synchronization[i];
    fill     = ptr_d - rbin;
    // Writer one full lap ahead: top two Gray bits differ, the rest match
    full_cmp = {~r_synchronization[ADDR_WIDTH:ADDR_WIDTH-1],
                r_synchronization[ADDR_WIDTH-2:0]};
    full_d   = (gray_d == full_cmp);
    // full folded in so almost_full can never lag behind full
    afull_d  = (fill >= AFULL_L) | full_d;
  end

  // Pointer, strobe and flag registers; reset beats any write request
  always_ff @(posedge write_clk) begin
    if (write_rst) begin
      ptr_q   <= '0;
      gray_q  <= '0;
      addr_q  <= '0;
      wen_q   <= 1'b0;
      full_q  <= 1'b0;
      afull_q <= 1'b0;
    end else begin
      ptr_q   <= ptr_d;
      gray_q  <= gray_d;
      addr_q  <= addr_d;
      wen_q   <= accept;
      full_q  <= full_d;
      afull_q <= afull_d;
    end
  end

`ifdef WRITE_OVERFLOW_FLAG_EN
  logic ovf_q;
  // Sticky record of any write attempted while full
  always_ff @(posedge write_clk) begin
    if (write_rst)                    ovf_q <= 1'b0;
    else if (write_enable && full_q)  ovf_q <= 1'b1;
  end
  assign overflow = ovf_q;
`endif

  assign full             = full_q;
  assign almost_full      = afull_q;
  assign write_addr_out   = addr_q;
  assign write_enable_out = wen_q;
  assign write_addr_gray  = gray_q;

endmodule
